// File: rtl/regfile_operand_fetch.sv
// regfile_operand_fetch: issue -> regfile read -> write forwarding -> 2-entry snooping output buffer
module regfile_operand_fetch #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 8,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_rs1_en,
  input  logic [ADDR_W-1:0] in_rs1_addr,
  input  logic              in_rs2_en,
  input  logic [ADDR_W-1:0] in_rs2_addr,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              rs1_read,
  output logic [ADDR_W-1:0] rs1_addr,
  input  logic [DATA_W-1:0] rs1_rdata,
  output logic              rs2_read,
  output logic [ADDR_W-1:0] rs2_addr,
  input  logic [DATA_W-1:0] rs2_rdata,
  input  logic              wb_write,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [TAG_W-1:0]  out_tag
);
  typedef struct packed {
    logic              need;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } opnd_t;
  typedef struct packed {
    opnd_t [1:0]      op;
    logic [TAG_W-1:0] tag;
  } ent_t;
  logic                   a_valid_q, a_valid_d;
  opnd_t [1:0]            a_op_q, a_op_d;
  logic [1:0]             a_byp_q, a_byp_d;
  logic [TAG_W-1:0]       a_tag_q, a_tag_d;
  ent_t [1:0]             fifo_q, fifo_d;
  logic [1:0]             count_q, count_d;
  logic [1:0]             in_en, need_in;
  logic [1:0][ADDR_W-1:0] in_addr;
  logic [1:0][DATA_W-1:0] rdata;
  logic                   accept, pop;
  logic [1:0]             base;
  ent_t                   new_ent;
  ent_t [1:0]             snoop;
  assign in_en     = {in_rs2_en, in_rs1_en};
  assign in_addr   = {in_rs2_addr, in_rs1_addr};
  assign rdata     = {rs2_rdata, rs1_rdata};
  assign out_valid = count_q != 2'd0;
  assign pop       = out_valid && out_ready;
  assign in_ready  = rst_n && ({1'b0, a_valid_q} + count_q - {1'b0, pop}) < 2'd2;
  assign accept    = in_valid && in_ready;
  assign rs1_read  = accept && need_in[0];
  assign rs2_read  = accept && need_in[1];
  assign rs1_addr  = in_rs1_addr;
  assign rs2_addr  = in_rs2_addr;
  assign out_op1   = fifo_q[0].op[0].data;
  assign out_op2   = fifo_q[0].op[1].data;
  assign out_tag   = fifo_q[0].tag;
  // Decode the issue request and catch a write landing in the same cycle as the read
  always_comb begin
    need_in   = '0;
    a_op_d    = '0;
    a_byp_d   = '0;
    a_valid_d = accept;
    a_tag_d   = in_tag;
    for (int i = 0; i < 2; i++) begin
      need_in[i]     = in_en[i] && !(ZERO_REG && in_addr[i] == '0);
      a_op_d[i].need = need_in[i];
      a_op_d[i].addr = in_addr[i];
      a_op_d[i].data = wb_wdata;
      a_byp_d[i]     = wb_write && wb_addr == in_addr[i];
    end
  end
  // Pick each operand: newest write this cycle beats a captured bypass beats macro data
  always_comb begin
    new_ent     = '0;
    new_ent.tag = a_tag_q;
    for (int i = 0; i < 2; i++) begin
      new_ent.op[i].need = a_op_q[i].need;
      new_ent.op[i].addr = a_op_q[i].addr;
      new_ent.op[i].data = !a_op_q[i].need ? '0 :
                           (wb_write && wb_addr == a_op_q[i].addr) ? wb_wdata :
                           a_byp_q[i] ? a_op_q[i].data : rdata[i];
    end
  end
  // Held entries absorb every write to their registers; then pop shifts and stage A appends
  always_comb begin
    snoop = fifo_q;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 2; i++)
        if (wb_write && fifo_q[j].op[i].need && fifo_q[j].op[i].addr == wb_addr)
          snoop[j].op[i].data = wb_wdata;
    fifo_d = pop ? {snoop[1], snoop[1]} : snoop;
    base   = count_q - {1'b0, pop};
    if (a_valid_q)
      fifo_d[base[0]] = new_ent;
    count_d = base + {1'b0, a_valid_q};
  end
  // State registers; reset drops everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_op_q    <= '0;
      a_byp_q   <= '0;
      a_tag_q   <= '0;
      fifo_q    <= '0;
      count_q   <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_op_q    <= a_op_d;
      a_byp_q   <= a_byp_d;
      a_tag_q   <= a_tag_d;
      fifo_q    <= fifo_d;
      count_q   <= count_d;
    end
  end
endmodule

// File: tb/tb_regfile_operand_fetch.sv
// tb_regfile_operand_fetch: directed scenarios plus randomized traffic against an architectural-state model
module tb_regfile_operand_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        in_rs1_en = 1'b0, in_rs2_en = 1'b0;
  logic [3:0]  in_rs1_addr = '0, in_rs2_addr = '0;
  logic [7:0]  in_tag = '0;
  logic        rs1_read, rs2_read;
  logic [3:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_rdata = '0, rs2_rdata = '0;
  logic        wb_write = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_wdata = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_op1, out_op2;
  logic [7:0]  out_tag;
  logic [31:0] regs [16];
  int vecs = 0;
  int miss = 0;
  typedef struct {
    logic       en1;
    logic [3:0] a1;
    logic       en2;
    logic [3:0] a2;
    logic [7:0] tag;
    int         acc;
  } bundle_t;
  bundle_t q[$];

  always #5 clk = ~clk;

  regfile_operand_fetch #(.ADDR_W(4), .DATA_W(32), .TAG_W(8), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_en(in_rs1_en), .in_rs1_addr(in_rs1_addr), .in_rs2_en(in_rs2_en), .in_rs2_addr(in_rs2_addr),
    .in_tag(in_tag), .rs1_read(rs1_read), .rs1_addr(rs1_addr), .rs1_rdata(rs1_rdata),
    .rs2_read(rs2_read), .rs2_addr(rs2_addr), .rs2_rdata(rs2_rdata),
    .wb_write(wb_write), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2), .out_tag(out_tag)
  );

  // Regfile macro: 1-cycle read of pre-write contents, garbage when not read
  always @(posedge clk) begin
    rs1_rdata <= rs1_read ? regs[rs1_addr] : $urandom;
    rs2_rdata <= rs2_read ? regs[rs2_addr] : $urandom;
    if (wb_write) regs[wb_addr] <= wb_wdata;
  end

  function automatic logic [31:0] arch(logic en, logic [3:0] a);
    return (en && a != 4'd0) ? regs[a] : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_rs1_en = 0; in_rs2_en = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_tag = 0;
    wb_write = 0; wb_addr = 0; wb_wdata = 0;
  endtask

  task automatic issue(logic e1, logic [3:0] a1, logic e2, logic [3:0] a2, logic [7:0] t);
    in_valid = 1; in_rs1_en = e1; in_rs1_addr = a1; in_rs2_en = e2; in_rs2_addr = a2; in_tag = t;
  endtask

  task automatic wb(logic [3:0] a, logic [31:0] d);
    wb_write = 1; wb_addr = a; wb_wdata = d;
  endtask

  task automatic preload(logic [3:0] a, logic [31:0] d);
    idle();
    wb(a, d);
    step();
    wb_write = 0;
  endtask

  task automatic test_reset();
    idle();
    out_ready = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({out_valid, rs1_read, rs2_read} !== 3'b000) begin
      miss++; $display("FAIL reset_ctl: got %b expected 000", {out_valid, rs1_read, rs2_read});
    end
    vecs++;
    if ({out_op1, out_op2, out_tag} !== 72'd0) begin
      miss++; $display("FAIL reset_data: got %h expected 0", {out_op1, out_op2, out_tag});
    end
    rst_n = 1;
    @(negedge clk);
    vecs++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miss++; $display("FAIL reset_release: got %b expected 10", {in_ready, out_valid});
    end
    step();
    for (int i = 0; i < 16; i++) preload(4'(i), 32'h1000_0000 + 32'(i) * 32'h0101);
  endtask

  task automatic test_basic();
    preload(3, 32'h11);
    preload(5, 32'h22);
    out_ready = 1;
    issue(1, 3, 1, 5, 8'h5A);
    @(negedge clk);
    vecs++;
    if ({rs1_read, rs2_read, rs1_addr, rs2_addr} !== {2'b11, 4'd3, 4'd5}) begin
      miss++; $display("FAIL read_strobe: got %h expected %h", {rs1_read, rs2_read, rs1_addr, rs2_addr}, {2'b11, 4'd3, 4'd5});
    end
    step();
    idle();
    @(negedge clk);
    vecs++;
    if ({rs1_read, rs2_read, out_valid} !== 3'b000) begin
      miss++; $display("FAIL basic_c1: got %b expected 000", {rs1_read, rs2_read, out_valid});
    end
    step();
    @(negedge clk);
    vecs++;
    if ({out_valid, out_op1, out_op2, out_tag} !== {1'b1, 32'h11, 32'h22, 8'h5A}) begin
      miss++; $display("FAIL basic_c2: got %h expected %h", {out_valid, out_op1, out_op2, out_tag}, {1'b1, 32'h11, 32'h22, 8'h5A});
    end
    step();
    @(negedge clk);
    vecs++;
    if (out_valid !== 1'b0) begin
      miss++; $display("FAIL basic_single: got out_valid %b expected 0", out_valid);
    end
    step();
  endtask

  task automatic test_bypass();
    preload(4, 32'h1234);
    out_ready = 1;
    issue(1, 4, 0, 9, 8'h21);
    wb(4, 32'hAAAA);
    step();
    idle();
    step();
    @(negedge clk);
    vecs++;
    if ({out_valid, out_op1, out_op2, out_tag} !== {1'b1, 32'hAAAA, 32'h0, 8'h21}) begin
      miss++; $display("FAIL bypass_c: got %h expected %h", {out_valid, out_op1, out_op2, out_tag}, {1'b1, 32'hAAAA, 32'h0, 8'h21});
    end
    step();
  endtask

  task automatic test_bypass_late();
    preload(4, 32'h1234);
    issue(1, 4, 1, 4, 8'h22);
    step();
    idle();
    wb(4, 32'hBBBB);
    step();
    wb_write = 0;
    @(negedge clk);
    vecs++;
    if ({out_valid, out_op1, out_op2, out_tag} !== {1'b1, 32'hBBBB, 32'hBBBB, 8'h22}) begin
      miss++; $display("FAIL bypass_c1: got %h expected %h", {out_valid, out_op1, out_op2, out_tag}, {1'b1, 32'hBBBB, 32'hBBBB, 8'h22});
    end
    step();
    preload(4, 32'h1234);
    issue(1, 4, 0, 0, 8'h23);
    wb(4, 32'hC1);
    step();
    idle();
    wb(4, 32'hC2);
    step();
    wb_write = 0;
    @(negedge clk);
    vecs++;
    if ({out_valid, out_op1, out_tag} !== {1'b1, 32'hC2, 8'h23}) begin
      miss++; $display("FAIL bypass_both: got %h expected %h", {out_valid, out_op1, out_tag}, {1'b1, 32'hC2, 8'h23});
    end
    step();
  endtask

  task automatic test_zero();
    out_ready = 1;
    idle();
    issue(1, 0, 0, 5, 8'h30);
    wb(0, 32'hFFFF);
    @(negedge clk);
    vecs++;
    if ({rs1_read, rs2_read} !== 2'b00) begin
      miss++; $display("FAIL zero_read: got %b expected 00", {rs1_read, rs2_read});
    end
    step();
    idle();
    wb(0, 32'hEEEE);
    step();
    wb_write = 0;
    @(negedge clk);
    vecs++;
    if ({out_valid, out_op1, out_op2, out_tag} !== {1'b1, 32'h0, 32'h0, 8'h30}) begin
      miss++; $display("FAIL zero_ops: got %h expected %h", {out_valid, out_op1, out_op2, out_tag}, {1'b1, 32'h0, 32'h0, 8'h30});
    end
    step();
  endtask

  task automatic test_stall();
    int  issued = 0;
    int  popped = 0;
    logic acc;
    preload(7, 32'h70);
    preload(2, 32'h2);
    for (int k = 0; k < 20 && popped < 3; k++) begin
      out_ready = (k >= 5);
      if (issued < 3) issue(1, 7, 1, 2, 8'(issued + 1));
      else in_valid = 0;
      wb_write = (k == 3); wb_addr = 7; wb_wdata = 32'h77;
      @(negedge clk);
      if (k == 2) begin
        vecs++;
        if (in_ready !== 1'b0) begin
          miss++; $display("FAIL stall_ready: got %b expected 0", in_ready);
        end
      end
      if (k == 4) begin
        vecs++;
        if ({out_valid, out_tag, out_op1} !== {1'b1, 8'd1, 32'h77}) begin
          miss++; $display("FAIL stall_snoop: got %h expected %h", {out_valid, out_tag, out_op1}, {1'b1, 8'd1, 32'h77});
        end
      end
      if (out_valid && out_ready) begin
        vecs++;
        if ({out_tag, out_op1, out_op2} !== {8'(popped + 1), 32'h77, 32'h2}) begin
          miss++; $display("FAIL stall_drain: got %h expected %h", {out_tag, out_op1, out_op2}, {8'(popped + 1), 32'h77, 32'h2});
        end
        popped++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) issued++;
    end
    idle();
    vecs++;
    if (popped != 3) begin
      miss++; $display("FAIL stall_count: got %0d bundles expected 3", popped);
    end
    out_ready = 1;
    repeat (3) step();
  endtask

  task automatic test_random();
    int n = 1500;
    logic pop, exp_ready, exp_valid;
    bundle_t b;
    q.delete();
    for (int c = 0; c < n + 20; c++) begin
      if (c < n) begin
        in_valid = $urandom_range(9) < 7;
        in_rs1_en = $urandom_range(3) != 0; in_rs1_addr = 4'($urandom_range(7));
        in_rs2_en = $urandom_range(3) != 0; in_rs2_addr = 4'($urandom_range(7));
        in_tag = 8'($urandom);
        wb_write = $urandom_range(1) == 1; wb_addr = 4'($urandom_range(7)); wb_wdata = $urandom;
        out_ready = $urandom_range(9) < 6;
      end else begin
        idle();
        out_ready = 1;
      end
      @(negedge clk);
      pop = out_valid && out_ready;
      exp_ready = (q.size() - (pop ? 1 : 0)) < 2;
      exp_valid = q.size() > 0 && q[0].acc <= c - 2;
      vecs++;
      if ({in_ready, out_valid} !== {exp_ready, exp_valid}) begin
        miss++; $display("FAIL rnd_flow c=%0d: got %b expected %b", c, {in_ready, out_valid}, {exp_ready, exp_valid});
      end
      vecs++;
      if ({rs1_read, rs2_read} !== {in_valid && exp_ready && in_rs1_en && in_rs1_addr != 0,
                                    in_valid && exp_ready && in_rs2_en && in_rs2_addr != 0}) begin
        miss++; $display("FAIL rnd_read c=%0d: got %b", c, {rs1_read, rs2_read});
      end
      if (pop && q.size() > 0) begin
        b = q.pop_front();
        vecs++;
        if ({out_op1, out_op2, out_tag} !== {arch(b.en1, b.a1), arch(b.en2, b.a2), b.tag}) begin
          miss++; $display("FAIL rnd_data c=%0d: got %h expected %h", c, {out_op1, out_op2, out_tag},
                           {arch(b.en1, b.a1), arch(b.en2, b.a2), b.tag});
        end
      end
      if (in_valid && in_ready) q.push_back('{in_rs1_en, in_rs1_addr, in_rs2_en, in_rs2_addr, in_tag, c});
      step();
    end
    vecs++;
    if (q.size() != 0) begin
      miss++; $display("FAIL rnd_drain: got %0d bundles left expected 0", q.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    issue(1, 3, 1, 5, 8'h41);
    step();
    issue(1, 5, 1, 3, 8'h42);
    step();
    idle();
    step();
    @(negedge clk);
    vecs++;
    if ({out_valid, in_ready, out_tag} !== {2'b10, 8'h41}) begin
      miss++; $display("FAIL rstmid_full: got %h expected %h", {out_valid, in_ready, out_tag}, {2'b10, 8'h41});
    end
    rst_n = 0;
    #1;
    vecs++;
    if ({out_valid, out_op1, out_tag} !== 41'd0) begin
      miss++; $display("FAIL rstmid_async: got %h expected 0", {out_valid, out_op1, out_tag});
    end
    step();
    out_ready = 1;
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vecs++;
      if (out_valid !== 1'b0) begin
        miss++; $display("FAIL rstmid_stale: got out_valid %b expected 0 at cycle %0d", out_valid, k);
      end
      step();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_bypass_late();
    test_zero();
    test_stall();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
